wdt_ctrl: RTL and testbench

//  System-clock (clk) register front end and sequencer for the watchdog timer.

---
 rtl/wdt_ctrl.sv | 151 +++++++++++++++
 tb/tb_wdt_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/wdt_ctrl.sv
// Watchdog register front end: programs count/enable, stretches keyed kicks into wdlive pulses,
// synchronises WTO back and holds it as sticky status/irq. Bus response 1 cycle; ready low while kicking.
module wdt_ctrl #(
  parameter int          KICK_HOLD = 4,
  parameter logic [31:0] KICK_KEY  = 32'h5A5A_A5A5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [3:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  input  logic        wto_in,
  output logic        wden,
  output logic        wdlive,
  output logic [31:0] wtocnt,
  output logic        irq
);

  localparam int            KW    = $clog2(KICK_HOLD + 1);
  localparam logic [KW-1:0] KLOAD = KW'(KICK_HOLD);

  typedef enum logic [1:0] {
    S_DIS  = 2'b00,
    S_ARM  = 2'b01,
    S_KICK = 2'b10,
    S_TO   = 2'b11
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [KW-1:0] r_kcnt;
  logic          r_wto_s1;
  logic          r_wto_s2;
  logic          r_to;
  logic          r_err;
  logic [31:0]   r_wtocnt;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_rdata;

  logic          w_acc;
  logic          w_wr;
  logic          w_to_evt;
  logic          w_wr_ctrl;
  logic          w_wr_cnt;
  logic          w_wr_kick;
  logic          w_wr_stat;
  logic          w_wr_unmapped;
  logic          w_kick_ok;
  logic          w_en_off;
  logic          w_err_set;
  logic          w_to_set;
  logic [31:0]   w_rdata;

  assign w_acc         = req_valid && req_ready;
  assign w_wr          = w_acc && req_write;
  assign w_to_evt      = r_wto_s2;
  assign w_wr_ctrl     = w_wr && (req_addr == 4'h0);
  assign w_wr_cnt      = w_wr && (req_addr == 4'h4);
  assign w_wr_kick     = w_wr && (req_addr == 4'h8);
  assign w_wr_stat     = w_wr && (req_addr == 4'hC);
  assign w_wr_unmapped = w_wr && (req_addr[1:0] != 2'b00);
  assign w_kick_ok     = w_wr_kick && (req_wdata == KICK_KEY) && (r_state == S_ARM);
  assign w_en_off      = w_wr_ctrl && !req_wdata[0];

  // A correctly keyed kick in ARMED never flags ERR, even when a timeout pre-empts it.
  assign w_err_set = (w_wr_cnt && (r_state != S_DIS))
                   || (w_wr_ctrl && req_wdata[0] && (r_wtocnt == 32'd0))
                   || (w_wr_kick && !w_kick_ok)
                   || w_wr_unmapped;

  // Level-driven so a W1C racing an asserted timeout leaves TO set.
  assign w_to_set = w_to_evt && (r_state != S_DIS);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_DIS;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_DIS:  if (w_wr_ctrl && req_wdata[0] && (r_wtocnt != 32'd0)) w_state_nxt = S_ARM;
      S_ARM: begin
        if (w_to_evt)       w_state_nxt = S_TO;
        else if (w_kick_ok) w_state_nxt = S_KICK;
        else if (w_en_off)  w_state_nxt = S_DIS;
      end
      S_KICK: begin
        if (w_to_evt)                 w_state_nxt = S_TO;
        else if (r_kcnt <= KW'(1))    w_state_nxt = S_ARM;
      end
      S_TO:   if (w_en_off) w_state_nxt = S_DIS;
      default: w_state_nxt = S_DIS;
    endcase
  end

  always_comb begin
    wden      = (r_state != S_DIS);
    wdlive    = (r_state == S_KICK);
    req_ready = (r_state != S_KICK);
  end

  always_comb begin
    w_rdata = 32'd0;
    case (req_addr)
      4'h0:    w_rdata = {31'd0, wden};
      4'h4:    w_rdata = r_wtocnt;
      4'hC:    w_rdata = {28'd0, r_state, r_err, r_to};
      default: w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_kcnt      <= '0;
      r_wto_s1    <= 1'b0;
      r_wto_s2    <= 1'b0;
      r_to        <= 1'b0;
      r_err       <= 1'b0;
      r_wtocnt    <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
    end else begin
      r_wto_s1    <= wto_in;
      r_wto_s2    <= r_wto_s1;
      r_rsp_valid <= w_acc;
      r_rsp_rdata <= (w_acc && !req_write) ? w_rdata : 32'd0;
      if (w_wr_cnt && (r_state == S_DIS)) r_wtocnt <= req_wdata;
      r_to  <= (r_to && !(w_wr_stat && req_wdata[0])) || w_to_set;
      r_err <= (r_err && !(w_wr_stat && req_wdata[1])) || w_err_set;
      if ((w_state_nxt == S_KICK) && (r_state != S_KICK)) begin
        r_kcnt <= KLOAD;
      end else if ((r_state == S_KICK) && (r_kcnt != '0)) begin
        r_kcnt <= r_kcnt - KW'(1);
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign wtocnt    = r_wtocnt;
  assign irq       = r_to;

endmodule

// File: tb/tb_wdt_ctrl.sv
// Directed bench for wdt_ctrl: register access, kick stretching, timeout capture and W1C corners.
module tb_wdt_ctrl;
  localparam logic [31:0] KEY = 32'h5A5A_A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [3:0]  req_addr = 4'h0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        wto_in = 1'b0;
  logic        wden;
  logic        wdlive;
  logic [31:0] wtocnt;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  wdt_ctrl #(.KICK_HOLD(4), .KICK_KEY(KEY)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .wto_in(wto_in), .wden(wden), .wdlive(wdlive), .wtocnt(wtocnt), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one request on a falling edge, returns just after the accepting rising edge.
  task automatic bus(input logic wr, input logic [3:0] a, input logic [31:0] d,
                     output logic [31:0] rd);
    int w;
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("bus_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rd = rsp_rdata;
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    if (wr) chk("wr_rdata", rsp_rdata, 32'd0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] rd;
    bus(1'b1, a, d, rd);
  endtask

  task automatic rdchk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    bus(1'b0, a, 32'd0, rd);
    chk(tag, rd, exp);
  endtask

  initial begin
    int live_cnt;
    int nrdy_cnt;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_wden", {31'd0, wden}, 32'd0);
    chk("rst_wdlive", {31'd0, wdlive}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_wtocnt", wtocnt, 32'd0);
    rdchk("rst_status", 4'hC, 32'h0);

    wr(4'h4, 32'd100);
    chk("wtocnt_100", wtocnt, 32'd100);
    wr(4'h0, 32'd1);
    chk("wden_on", {31'd0, wden}, 32'd1);
    rdchk("status_armed", 4'hC, 32'h4);
    wr(4'h4, 32'd5);
    rdchk("status_cnt_err", 4'hC, 32'h6);
    rdchk("cnt_kept", 4'h4, 32'd100);
    rdchk("ctrl_rd", 4'h0, 32'd1);
    wr(4'hC, 32'h2);
    rdchk("err_cleared", 4'hC, 32'h4);

    // Valid kick: 4 cycles of wdlive and of req_ready low.
    wr(4'h8, KEY);
    live_cnt = 0;
    nrdy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (wdlive) live_cnt++;
      if (!req_ready) nrdy_cnt++;
      @(posedge clk);
      #1;
    end
    chk("kick_live_cycles", live_cnt, 32'd4);
    chk("kick_nrdy_cycles", nrdy_cnt, 32'd4);
    rdchk("status_after_kick", 4'hC, 32'h4);

    wr(4'h8, 32'h1234);
    chk("badkey_nolive", {31'd0, wdlive}, 32'd0);
    rdchk("status_badkey", 4'hC, 32'h6);
    wr(4'hC, 32'h2);
    rdchk("kick_reads0", 4'h8, 32'h0);
    wr(4'h1, 32'hFFFF_FFFF);
    rdchk("status_unmapped", 4'hC, 32'h6);
    rdchk("unmapped_rd", 4'h1, 32'h0);
    wr(4'hC, 32'h2);
    rdchk("status_clean", 4'hC, 32'h4);

    // Timeout: two sync flops then the state edge.
    wto_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("to_irq", {31'd0, irq}, 32'd1);
    chk("to_wden", {31'd0, wden}, 32'd1);
    rdchk("status_timeout", 4'hC, 32'hD);
    wr(4'h8, KEY);
    chk("to_kick_nolive", {31'd0, wdlive}, 32'd0);
    rdchk("status_to_kick", 4'hC, 32'hF);
    wr(4'hC, 32'h3);
    rdchk("w1c_wto_high", 4'hC, 32'hD);
    chk("irq_held", {31'd0, irq}, 32'd1);
    wto_in = 1'b0;
    repeat (3) @(posedge clk);
    wr(4'hC, 32'h3);
    rdchk("w1c_wto_low", 4'hC, 32'hC);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    wr(4'h0, 32'd0);
    chk("wden_off", {31'd0, wden}, 32'd0);
    rdchk("status_disabled", 4'hC, 32'h0);

    // Timeout arriving mid-kick aborts the pulse after 3 cycles.
    wr(4'h0, 32'd1);
    wr(4'h8, KEY);
    chk("abort_live_start", {31'd0, wdlive}, 32'd1);
    wto_in = 1'b1;
    live_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (wdlive) live_cnt++;
      @(posedge clk);
      #1;
    end
    chk("abort_live_cycles", live_cnt, 32'd3);
    rdchk("status_abort", 4'hC, 32'hD);

    wto_in = 1'b0;
    repeat (3) @(posedge clk);
    wr(4'h0, 32'd0);
    wr(4'hC, 32'h3);
    rdchk("status_recover", 4'hC, 32'h0);

    // Reset in the middle of a kick.
    wr(4'h0, 32'd1);
    wr(4'h8, KEY);
    chk("rstkick_live", {31'd0, wdlive}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstkick_wdlive", {31'd0, wdlive}, 32'd0);
    chk("rstkick_wden", {31'd0, wden}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rdchk("rstkick_status", 4'hC, 32'h0);
    rdchk("rstkick_cnt", 4'h4, 32'h0);

    // Timeout and valid kick accepted on the same edge: timeout wins, no ERR.
    wr(4'h4, 32'd50);
    wr(4'h0, 32'd1);
    @(negedge clk);
    wto_in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    wr(4'h8, KEY);
    chk("race_nolive", {31'd0, wdlive}, 32'd0);
    rdchk("race_status", 4'hC, 32'hD);
    wto_in = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
